// File: rtl/cone_out_fifo.sv
// Output FIFO for the cone result vector: DEPTH-entry ring buffer with
// sticky overflow and a saturating count of accepted words that changed.
module cone_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [3:0]  count,
    output logic        overflow,
    output logic [15:0] toggle_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] FULL = 4'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic          r_overflow;
    logic [15:0]   r_toggle_cnt;
    logic [7:0]    r_last_word;

    logic w_push;
    logic w_pop;

    // Handshake flags come only from registered occupancy.
    assign in_ready   = (r_count != FULL);
    assign out_valid  = (r_count != 4'd0);
    assign out_data   = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign toggle_cnt = r_toggle_cnt;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= 4'd0;
            r_overflow   <= 1'b0;
            r_toggle_cnt <= 16'd0;
            r_last_word  <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
            // Toggle count saturates rather than wrapping.
            if (w_push) begin
                r_last_word <= in_data;
                if (in_data != r_last_word && r_toggle_cnt != 16'hFFFF) begin
                    r_toggle_cnt <= r_toggle_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cone_out_fifo.sv
// Bench for cone_out_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cone_out_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] toggle_cnt;

    int n_chk;
    int n_fail;

    logic [7:0]  m_q[$];
    logic        m_ovf;
    logic [15:0] m_tog;
    logic [7:0]  m_last;

    cone_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow),
        .toggle_cnt(toggle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step();
        bit full;
        bit do_push;
        bit do_pop;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_tog  = 16'd0;
            m_last = 8'd0;
        end else begin
            full    = (m_q.size() == DEPTH);
            do_push = in_valid && !full;
            do_pop  = (m_q.size() != 0) && out_ready;
            if (in_valid && full) m_ovf = 1'b1;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(in_data);
                if (in_data != m_last && m_tog != 16'hFFFF) m_tog++;
                m_last = in_data;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        in_valid = 1'b1;
        in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_data = 8'hA5;
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got ov=%b ir=%b cnt=%0d want 0 1 0",
                     out_valid, in_ready, count);
        end
        n_chk++;
        if (overflow !== 1'b0 || toggle_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stat: got ovf=%b tog=%h want 0 0000",
                     overflow, toggle_cnt);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        push_word(8'h11);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL latency1: got v=%b d=%h want 1 11",
                     out_valid, out_data);
        end
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        n_chk++;
        if (count !== 4'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got cnt=%0d ir=%b want 4 0",
                     count, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
                n_fail++;
                $display("FAIL drain_%0d: got v=%b d=%h want 1 %h",
                         i, out_valid, out_data, exp_w[i]);
            end
            cyc();
        end
        out_ready = 1'b0;
        n_chk++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got cnt=%0d v=%b want 0 0",
                     count, out_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        push_word(8'h55);
        n_chk++;
        if (overflow !== 1'b1 || count !== 4'd4) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b cnt=%0d want 1 4",
                     overflow, count);
        end
        n_chk++;
        if (toggle_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL ovf_tog: got %0d want 4", toggle_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (out_data !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_order_%0d: got %h want %h",
                         i, out_data, 8'hA0 + 8'(i));
            end
            cyc();
        end
        cyc();
        cyc();
        out_ready = 1'b0;
        n_chk++;
        if (overflow !== 1'b1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b cnt=%0d want 1 0",
                     overflow, count);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
        in_valid = 1'b1;
        in_data = 8'h66;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_chk++;
        if (count !== 4'd3 || overflow !== 1'b1 || out_data !== 8'hC1) begin
            n_fail++;
            $display("FAIL full_pop: got cnt=%0d ovf=%b d=%h want 3 1 c1",
                     count, overflow, out_data);
        end
    endtask

    task automatic test_toggle();
        logic [7:0] seq [5] = '{8'h00, 8'h00, 8'h0F, 8'h0F, 8'hF0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(seq[i]);
        n_chk++;
        if (toggle_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL toggle_basic: got %0d want 2", toggle_cnt);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            in_data = i[0] ? 8'hAA : 8'h55;
            cyc();
        end
        in_valid = 1'b0;
        n_chk++;
        if (toggle_cnt !== 16'hFFFF || toggle_cnt !== m_tog) begin
            n_fail++;
            $display("FAIL toggle_sat: got %h want ffff", toggle_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'h80 + 8'(i);
            cyc();
            n_chk++;
            if (count > 4'd1 || out_valid !== 1'b1 || out_data !== in_data) begin
                n_fail++;
                $display("FAIL stream_%0d: got cnt=%0d v=%b d=%h want <=1 1 %h",
                         i, count, out_valid, out_data, in_data);
            end
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        n_chk++;
        if (count !== 4'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got cnt=%0d ovf=%b want 0 0",
                     count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) push_word(8'h10 + 8'(i));
        n_chk++;
        if (count !== 4'd3) begin
            n_fail++;
            $display("FAIL mid_pre: got cnt=%0d want 3", count);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 ||
            toggle_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_rst: got cnt=%0d v=%b ovf=%b tog=%0d want 0 0 0 0",
                     count, out_valid, overflow, toggle_cnt);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            in_valid = ($urandom_range(99) < 60);
            out_ready = ($urandom_range(99) < 45);
            in_data = ($urandom_range(3) == 0) ? m_last : 8'($urandom);
            cyc();
            n_chk++;
            if (count !== 4'(m_q.size()) || overflow !== m_ovf ||
                toggle_cnt !== m_tog ||
                out_valid !== (m_q.size() != 0) ||
                in_ready !== (m_q.size() != DEPTH) ||
                (m_q.size() != 0 && out_data !== m_q[0])) begin
                n_fail++;
                if (bad < 5)
                    $display("FAIL random_%0d: got cnt=%0d ovf=%b tog=%0d d=%h want %0d %b %0d %h",
                             i, count, overflow, toggle_cnt, out_data,
                             m_q.size(), m_ovf, m_tog,
                             (m_q.size() != 0) ? m_q[0] : 8'h00);
                bad++;
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        m_ovf = 1'b0;
        m_tog = 16'd0;
        m_last = 8'd0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_pop();
        test_toggle();
        test_stream();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cone_out_fifo.md
CONE_OUT_FIFO -- requirements
Module: cone_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream result vector valid this cycle.
REQ-005 SHALL have port in_data  input  8  cone outputs, packed as bit0=n6, bit1=n9, bit2=n42, bit3=n48, bit4=n56, bit5=n65, bit6=n68, bit7=n77.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a word.
REQ-007 SHALL have port out_valid  output  1  head word available.
REQ-008 SHALL have port out_data  output  8  head word.
REQ-009 SHALL have port out_ready  input  1  downstream accepts head word.
REQ-010 SHALL have port count  output  4  occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a word was dropped.
REQ-012 SHALL have port toggle_cnt  output  16  number of accepted words differing from the previously accepted word.

Function
REQ-013 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-014 SHALL drive in_ready = (count != DEPTH), decoded from registered count only, with no combinational path from out_ready.
REQ-015 SHALL drive out_valid = (count != 0) and out_data = storage[rd_ptr], both from registered state only.
REQ-016 SHALL write in_data at wr_ptr on push and advance wr_ptr modulo DEPTH.
REQ-017 SHALL advance rd_ptr modulo DEPTH on pop.
REQ-018 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-019 SHALL give a push into an empty FIFO a latency of 1: out_valid=1 and out_data equal to the pushed word in the next cycle.
REQ-020 SHALL, when full, refuse to accept a word even if a pop occurs in the same cycle; in_ready is 0 for that cycle.
REQ-021 SHALL set overflow on any cycle with in_valid=1 and in_ready=0, drop the word without altering storage, pointers or toggle_cnt, and hold overflow at 1 until reset.
REQ-022 SHALL ignore a pop request when empty: no state change, and out_data is don't-care.
REQ-023 SHALL, on each push, compare in_data against last_word and increment toggle_cnt if they differ, then load last_word with in_data.
REQ-024 SHALL saturate toggle_cnt at 16'hFFFF, with no wrap-around.
REQ-025 SHALL preserve word order exactly; no reordering or duplication.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, clear count, wr_ptr, rd_ptr, overflow, toggle_cnt and last_word to 0; storage contents are not reset.
REQ-027 SHALL give rst priority over simultaneous push and pop; a word presented during the reset cycle is discarded and does not set overflow.
REQ-028 SHALL, in the cycle after reset, present out_valid=0, in_ready=1, count=0, overflow=0 and toggle_cnt=0.
REQ-029 SHALL, on reset mid-operation (any occupancy), lose all queued words; out_valid=0 next cycle.

Verification
REQ-030 SHALL cover fill and drain: DEPTH=4, push 8'h11, 22, 33, 44 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> 11, 22, 33, 44 emerge in order, count returns to 0.
REQ-031 SHALL cover overflow: FIFO full, in_valid=1 with 8'h55 -> overflow=1 and stays 1; 8'h55 never appears on out_data.
REQ-032 SHALL cover full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop occurs, no push, count=3, overflow=1.
REQ-033 SHALL cover toggle counting: after reset push 00, 00, 0F, 0F, F0 -> toggle_cnt=2; with the counter forced to FFFF, a further differing push -> toggle_cnt stays FFFF.
REQ-034 SHALL cover pointer wrap-around with streaming: in_valid=1 and out_ready=1 for 20 cycles with an incrementing data pattern -> count oscillates between 0 and 1, every word is output once in order, and overflow=0.
REQ-035 SHALL cover reset mid-operation: with count=3, assert rst for 1 cycle while in_valid=1 -> next cycle count=0, out_valid=0, overflow=0 and toggle_cnt=0.
